// File: rtl/s2_kes_dcme_param_if.sv
// Stage-2 key-equation solver bundle: start/syndromes in, locator/evaluator results out.
interface s2_kes_dcme_param_if #(
    parameter int T = 2
);
    logic               kes_ena;
    logic [16*T-1:0]    rs_syn;
    logic               kes_busy;
    logic               kes_done;
    logic               kes_overrun;
    logic [8*(T+1)-1:0] rs_lambda;
    logic [8*T-1:0]     rs_omega;
    logic [3:0]         rs_err_cnt;
    logic               rs_zero_syn;

    modport master (
        output kes_ena, rs_syn,
        input  kes_busy, kes_done, kes_overrun, rs_lambda, rs_omega, rs_err_cnt, rs_zero_syn
    );

    modport slave (
        input  kes_ena, rs_syn,
        output kes_busy, kes_done, kes_overrun, rs_lambda, rs_omega, rs_err_cnt, rs_zero_syn
    );
endinterface

// File: rtl/s2_kes_dcme_param.sv
// Degree-computationless modified Euclidean key-equation solver over GF(2^8), 2T+1 cycle latency.
// Produces the error locator and evaluator from 2T syndromes; all-zero syndromes take a 2-cycle fast path.
module s2_kes_dcme_param #(
    parameter int T  = 2,
    parameter int CW = 5
) (
    input  logic               clk,
    input  logic               rstn,
    s2_kes_dcme_param_if.slave kes
);
    localparam int N  = 2 * T;
    localparam int LW = 8 * (T + 1);

    typedef enum logic [1:0] {IDLE, ITER, FAST} state_t;
    typedef logic [N:0][7:0] rpoly_t;
    typedef logic [T:0][7:0] lpoly_t;

    state_t        st, st_n;
    rpoly_t        r, q, r_n, q_n, rc;
    lpoly_t        l, u, l_n, u_n, lc;
    logic [CW-1:0] dr, dq, dr_n, dq_n, it;
    logic [7:0]    a, b;
    logic [3:0]    deg_n;
    logic          syn_zero, last, udf;

    // Field polynomial x^8 + x^4 + x^3 + x^2 + 1.
    function automatic logic [7:0] gf2m8_multi(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    assign syn_zero = (kes.rs_syn == '0);
    assign last     = (it == CW'(N));
    assign a        = r[N];
    assign b        = q[N];

    for (genvar i = 0; i <= N; i++) begin : g_rc
        assign rc[i] = gf2m8_multi(b, r[i]) ^ gf2m8_multi(a, q[i]);
    end

    for (genvar k = 0; k <= T; k++) begin : g_lc
        assign lc[k] = gf2m8_multi(b, l[k]) ^ gf2m8_multi(a, u[k]);
    end

    // One DCME step; the top coefficients stay aligned at index 2T by shifting.
    always_comb begin
        r_n  = r;
        q_n  = q;
        l_n  = l;
        u_n  = u;
        dr_n = dr;
        dq_n = dq;
        udf  = 1'b0;
        if (a == 8'h00) begin
            r_n  = {r[N-1:0], 8'h00};
            l_n  = {l[T-1:0], 8'h00};
            dr_n = dr - CW'(1);
            udf  = (dr == '0);
        end else if (b == 8'h00) begin
            q_n  = {q[N-1:0], 8'h00};
            u_n  = {u[T-1:0], 8'h00};
            dq_n = dq - CW'(1);
            udf  = (dq == '0);
        end else begin
            r_n = {rc[N-1:0], 8'h00};
            l_n = lc;
            if (dr < dq) begin
                q_n  = r;
                u_n  = l;
                dr_n = dq - CW'(1);
                dq_n = dr;
                udf  = (dq == '0);
            end else begin
                dr_n = dr - CW'(1);
                udf  = (dr == '0);
            end
        end
    end

    always_comb begin
        deg_n = 4'd0;
        for (int k = 1; k <= T; k++)
            if (l_n[k] != 8'h00) deg_n = 4'(k);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else       st <= st_n;
    end

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    if (kes.kes_ena) st_n = syn_zero ? FAST : ITER;
            ITER:    if (last) st_n = IDLE;
            FAST:    st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    assign kes.kes_busy = (st != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r               <= '0;
            q               <= '0;
            l               <= '0;
            u               <= '0;
            dr              <= '0;
            dq              <= '0;
            it              <= '0;
            kes.kes_done    <= 1'b0;
            kes.kes_overrun <= 1'b0;
            kes.rs_lambda   <= '0;
            kes.rs_omega    <= '0;
            kes.rs_err_cnt  <= '0;
            kes.rs_zero_syn <= 1'b0;
        end else begin
            kes.kes_done    <= 1'b0;
            kes.kes_overrun <= kes.kes_ena && (st != IDLE);
            case (st)
                IDLE: if (kes.kes_ena) begin
                    r  <= {8'h01, {(8*N){1'b0}}};
                    q  <= {kes.rs_syn, 8'h00};
                    l  <= '0;
                    u  <= LW'(1);
                    dr <= CW'(N);
                    dq <= CW'(N - 1);
                    it <= CW'(1);
                end
                ITER: begin
                    r  <= r_n;
                    q  <= q_n;
                    l  <= l_n;
                    u  <= u_n;
                    dr <= dr_n;
                    dq <= dq_n;
                    it <= it + CW'(1);
                    if (last) begin
                        kes.kes_done    <= 1'b1;
                        kes.rs_lambda   <= l_n;
                        kes.rs_omega    <= r_n[N:T+1];
                        kes.rs_err_cnt  <= deg_n;
                        kes.rs_zero_syn <= 1'b0;
                    end
                end
                FAST: begin
                    kes.kes_done    <= 1'b1;
                    kes.rs_lambda   <= LW'(1);
                    kes.rs_omega    <= '0;
                    kes.rs_err_cnt  <= 4'd0;
                    kes.rs_zero_syn <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Degree registers can only wrap if the datapath is broken.
    always_ff @(posedge clk) begin
        if (rstn && st == ITER) assert (!udf);
    end
endmodule
